simmem_release_scheduler: RTL and testbench

Per-channel release sequencer for the simulated-memory response banks. For each of the two response channels (read data, write response), it picks one releasable AXI ID per transaction with round-robin fairness. It then issues a head-pop request to the linked-list bank, waits out the RAM read latency, and presents the popped entry downstream with a valid/ready handshake. It sits between the delay/releaser logic (source of `releasable_i`) and the linked-list bank RAM ports.

---
 rtl/simmem_pkg.sv | 19 +
 rtl/simmem_release_scheduler_if.sv | 38 +++
 rtl/simmem_rr_arbiter.sv | 31 +++
 rtl/simmem_release_scheduler.sv | 114 +++++++++++
 tb/tb_simmem_release_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simmem_pkg.sv
// Shared types for the simulated-memory response path: channel
// enumeration and the release sequencer state encoding.
package simmem_pkg;

  localparam int unsigned NumChannels = 2;

  typedef enum logic {
    READ_DATA  = 1'b0,
    WRITE_RESP = 1'b1
  } simmem_channel_e;

  typedef enum logic [1:0] {
    REL_IDLE = 2'd0,
    REL_POP  = 2'd1,
    REL_WAIT = 2'd2,
    REL_OUT  = 2'd3
  } release_state_e;

endpackage

// File: rtl/simmem_release_scheduler_if.sv
// Release scheduler bundle: releasable flags in, bank pop port and
// downstream valid/ready presentation per response channel.
interface simmem_release_scheduler_if #(
  parameter int unsigned IDWidth = 8
);
  import simmem_pkg::*;

  localparam int unsigned NumIds = 2 ** IDWidth;

  logic [NumChannels-1:0][NumIds-1:0]  releasable;
  logic [NumChannels-1:0]              pop_req;
  logic [NumChannels-1:0][IDWidth-1:0] pop_id;
  logic [NumChannels-1:0]              pop_gnt;
  logic [NumChannels-1:0]              out_valid;
  logic [NumChannels-1:0][IDWidth-1:0] out_id;
  logic [NumChannels-1:0]              out_ready;

  modport master (
    input  releasable,
    input  pop_gnt,
    input  out_ready,
    output pop_req,
    output pop_id,
    output out_valid,
    output out_id
  );

  modport slave (
    output releasable,
    output pop_gnt,
    output out_ready,
    input  pop_req,
    input  pop_id,
    input  out_valid,
    input  out_id
  );

endinterface

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin pick over all AXI IDs, searching upward
// from the ID after the last granted one and wrapping at the top.
module simmem_rr_arbiter #(
  parameter int unsigned IDWidth = 8
) (
  input  logic [2**IDWidth-1:0] req_i,
  input  logic [IDWidth-1:0]    last_i,
  output logic [IDWidth-1:0]    winner_o,
  output logic                  any_o
);

  localparam int unsigned NumIds = 2 ** IDWidth;

  logic [IDWidth-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester
  // after last_i is the final assignment; offset NumIds lands on last_i.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      idx = last_i + IDWidth'(i + 1);
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-channel release sequencer: pick a releasable ID, pop its head from
// the linked-list bank, wait out RAM latency, present it downstream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// REL_IDLE | nothing in flight, waiting for any releasable ID
// REL_POP  | pop_req high for pop_id, held until the bank grants
// REL_WAIT | pop accepted, counting down remaining RAM read latency
// REL_OUT  | out_valid high for pop_id, held until downstream ready
module simmem_release_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned IDWidth    = 8,
  parameter int unsigned RamLatency = 1
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  simmem_release_scheduler_if.master bus
);

  localparam int unsigned CntW = (RamLatency > 1) ? $clog2(RamLatency) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RamLatency - 1);

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_ch
    release_state_e     state_q;
    logic               pop_req_q;
    logic [IDWidth-1:0] pop_id_q;
    logic               out_valid_q;
    logic [IDWidth-1:0] out_id_q;
    logic [IDWidth-1:0] last_q;
    logic [CntW-1:0]    cnt_q;
    logic [CntW-1:0]    cnt_d;
    logic [IDWidth-1:0] winner;
    logic               any;

    simmem_rr_arbiter #(
      .IDWidth (IDWidth)
    ) u_arb (
      .req_i    (bus.releasable[ch]),
      .last_i   (last_q),
      .winner_o (winner),
      .any_o    (any)
    );

    assign cnt_d = cnt_q - CntW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= REL_IDLE;
        pop_req_q   <= 1'b0;
        pop_id_q    <= '0;
        out_valid_q <= 1'b0;
        out_id_q    <= '0;
        last_q      <= '1;
        cnt_q       <= '0;
      end else begin
        unique case (state_q)
          REL_IDLE: begin
            if (any) begin
              pop_id_q  <= winner;
              pop_req_q <= 1'b1;
              state_q   <= REL_POP;
            end
          end
          REL_POP: begin
            // The RR pointer only moves once the bank has really taken the pop.
            if (bus.pop_gnt[ch]) begin
              pop_req_q <= 1'b0;
              last_q    <= pop_id_q;
              if (RamLatency == 1) begin
                out_valid_q <= 1'b1;
                out_id_q    <= pop_id_q;
                state_q     <= REL_OUT;
              end else begin
                cnt_q   <= CntLoad;
                state_q <= REL_WAIT;
              end
            end
          end
          REL_WAIT: begin
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
              out_valid_q <= 1'b1;
              out_id_q    <= pop_id_q;
              state_q     <= REL_OUT;
            end
          end
          REL_OUT: begin
            // Bank rdata is held by the bank until this handshake completes.
            if (bus.out_ready[ch]) begin
              out_valid_q <= 1'b0;
              if (any) begin
                pop_id_q  <= winner;
                pop_req_q <= 1'b1;
                state_q   <= REL_POP;
              end else begin
                state_q <= REL_IDLE;
              end
            end
          end
          default: begin
            state_q <= REL_IDLE;
          end
        endcase
      end
    end

    assign bus.pop_req[ch]   = pop_req_q;
    assign bus.pop_id[ch]    = pop_id_q;
    assign bus.out_valid[ch] = out_valid_q;
    assign bus.out_id[ch]    = out_id_q;
  end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Scoreboard bench for simmem_release_scheduler: RamLatency=1 instance for
// ordering/handshake behaviour, RamLatency=3 instance for latency timing.
module tb_simmem_release_scheduler;
  import simmem_pkg::*;

  localparam int unsigned IDW = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  simmem_release_scheduler_if #(.IDWidth(IDW)) bus1 ();
  simmem_release_scheduler_if #(.IDWidth(IDW)) bus3 ();

  simmem_release_scheduler #(.IDWidth(IDW), .RamLatency(1)) u_dut1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus1.master)
  );

  simmem_release_scheduler #(.IDWidth(IDW), .RamLatency(3)) u_dut3 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus3.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hs[2]    = '{0, 0};
  int q0[$];
  int q1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Handshakes on the latency-1 instance are scored against the queues.
  always @(negedge clk_i) begin
    chk("excl", 32'(bus1.pop_req & bus1.out_valid), 32'd0);
    if (bus1.out_valid[0] && bus1.out_ready[0]) begin
      hs[0]++;
      if (q0.size() == 0) chk("sb0_underflow", 32'd1, 32'd0);
      else chk("sb0_id", 32'(bus1.out_id[0]), 32'(q0.pop_front()));
    end
    if (bus1.out_valid[1] && bus1.out_ready[1]) begin
      hs[1]++;
      if (q1.size() == 0) chk("sb1_underflow", 32'd1, 32'd0);
      else chk("sb1_id", 32'(bus1.out_id[1]), 32'(q1.pop_front()));
    end
  end

  task automatic drain(input int ch, input int n);
    int  base;
    bit  done;
    base = hs[ch];
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (bus1.out_valid[ch] && hs[ch] == base + n - 1) begin
        bus1.releasable[ch] = '0;
        done = 1'b1;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
    tick();
    tick();
    chk("drain_idle", 32'({bus1.pop_req[ch], bus1.out_valid[ch]}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus1.releasable = '0; bus1.pop_gnt = '0; bus1.out_ready = '0;
    bus3.releasable = '0; bus3.pop_gnt = '0; bus3.out_ready = '0;
    repeat (2) tick();
    chk("rst_pop_req", 32'(bus1.pop_req), 32'd0);
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_ids", 32'({bus1.pop_id, bus1.out_id}), 32'd0);
    rst_ni = 1'b1;
    tick();

    // single pop of ID 5, latency 1
    bus1.pop_gnt = 2'b11;
    bus1.out_ready = 2'b11;
    bus1.releasable[0][5] = 1'b1;
    q0.push_back(5);
    tick();
    chk("single_req", 32'(bus1.pop_req[0]), 32'd1);
    chk("single_pid", 32'(bus1.pop_id[0]), 32'd5);
    bus1.releasable[0] = '0;
    tick();
    chk("single_nreq", 32'(bus1.pop_req[0]), 32'd0);
    chk("single_valid", 32'(bus1.out_valid[0]), 32'd1);
    chk("single_oid", 32'(bus1.out_id[0]), 32'd5);
    tick();
    chk("single_idle", 32'({bus1.pop_req[0], bus1.out_valid[0]}), 32'd0);

    // backpressure: 10 cycles of out_ready low
    bus1.out_ready[0] = 1'b0;
    bus1.releasable[0][9] = 1'b1;
    q0.push_back(9);
    q0.push_back(12);
    tick();
    tick();
    bus1.releasable[0] = '0;
    bus1.releasable[0][12] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus1.out_valid[0]), 32'd1);
      chk("bp_oid", 32'(bus1.out_id[0]), 32'd9);
      chk("bp_noreq", 32'(bus1.pop_req[0]), 32'd0);
      tick();
    end
    bus1.out_ready[0] = 1'b1;
    tick();
    chk("bp_next_req", 32'(bus1.pop_req[0]), 32'd1);
    chk("bp_next_pid", 32'(bus1.pop_id[0]), 32'd12);
    bus1.releasable[0] = '0;
    tick();
    tick();
    chk("bp_idle", 32'({bus1.pop_req[0], bus1.out_valid[0]}), 32'd0);

    // reset while presenting ID 3
    bus1.out_ready[0] = 1'b0;
    bus1.releasable[0][3] = 1'b1;
    tick();
    bus1.releasable[0] = '0;
    tick();
    chk("pre_rst_valid", 32'(bus1.out_valid[0]), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus1.pop_req), 32'd0);
    chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("mid_rst_ids", 32'({bus1.pop_id, bus1.out_id}), 32'd0);
    tick();
    rst_ni = 1'b1;
    bus1.out_ready = 2'b11;
    bus1.releasable[0] = '1;
    q0.push_back(0);
    tick();
    chk("post_rst_req", 32'(bus1.pop_req[0]), 32'd1);
    chk("post_rst_pid", 32'(bus1.pop_id[0]), 32'd0);
    bus1.releasable[0] = '0;
    tick();
    tick();

    // round robin over 2, 5, 7 starting after last=0
    bus1.releasable[0][2] = 1'b1;
    bus1.releasable[0][5] = 1'b1;
    bus1.releasable[0][7] = 1'b1;
    q0.push_back(2); q0.push_back(5); q0.push_back(7);
    q0.push_back(2); q0.push_back(5);
    drain(0, 5);

    // wrap: last=255 then {0,255} gives 0 then 255
    bus1.releasable[0][255] = 1'b1;
    q0.push_back(255);
    drain(0, 1);
    bus1.releasable[0][0] = 1'b1;
    bus1.releasable[0][255] = 1'b1;
    q0.push_back(0);
    q0.push_back(255);
    drain(0, 2);

    // grant stall: 3 cycles without grant on ID 7
    bus1.pop_gnt[0] = 1'b0;
    bus1.releasable[0][7] = 1'b1;
    bus1.releasable[0][8] = 1'b1;
    q0.push_back(7);
    q0.push_back(8);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("gs_req", 32'(bus1.pop_req[0]), 32'd1);
      chk("gs_pid", 32'(bus1.pop_id[0]), 32'd7);
      chk("gs_novalid", 32'(bus1.out_valid[0]), 32'd0);
      if (i == 3) bus1.pop_gnt[0] = 1'b1;
      tick();
    end
    chk("gs_valid", 32'(bus1.out_valid[0]), 32'd1);
    chk("gs_oid", 32'(bus1.out_id[0]), 32'd7);
    drain(0, 2);

    // channel independence: ch0 stalled on ID 4, ch1 streams 1, 3
    begin
      int  base1;
      bit  done;
      bus1.out_ready[0] = 1'b0;
      bus1.releasable[0][4] = 1'b1;
      bus1.releasable[1][1] = 1'b1;
      bus1.releasable[1][3] = 1'b1;
      q0.push_back(4);
      q1.push_back(1); q1.push_back(3); q1.push_back(1); q1.push_back(3);
      base1 = hs[1];
      done = 1'b0;
      tick();
      tick();
      bus1.releasable[0] = '0;
      for (int k = 0; k < 100 && !done; k++) begin
        tick();
        chk("ind_ch0_valid", 32'(bus1.out_valid[0]), 32'd1);
        chk("ind_ch0_oid", 32'(bus1.out_id[0]), 32'd4);
        chk("ind_ch0_noreq", 32'(bus1.pop_req[0]), 32'd0);
        if (bus1.out_valid[1] && hs[1] == base1 + 3) begin
          bus1.releasable[1] = '0;
          done = 1'b1;
        end
      end
      chk("ind_done", 32'(done), 32'd1);
      bus1.out_ready[0] = 1'b1;
      tick();
      tick();
      chk("ind_idle", 32'({bus1.pop_req, bus1.out_valid}), 32'd0);
    end

    // latency 3: grant at cycle 1, out_valid at cycle 4
    bus3.pop_gnt = 2'b11;
    bus3.releasable[0][6] = 1'b1;
    tick();
    chk("l3_req", 32'(bus3.pop_req[0]), 32'd1);
    chk("l3_pid", 32'(bus3.pop_id[0]), 32'd6);
    bus3.releasable[0] = '0;
    tick();
    chk("l3_wait1", 32'({bus3.pop_req[0], bus3.out_valid[0]}), 32'd0);
    tick();
    chk("l3_wait2", 32'({bus3.pop_req[0], bus3.out_valid[0]}), 32'd0);
    tick();
    chk("l3_valid", 32'(bus3.out_valid[0]), 32'd1);
    chk("l3_oid", 32'(bus3.out_id[0]), 32'd6);
    tick();
    chk("l3_hold", 32'(bus3.out_valid[0]), 32'd1);
    bus3.out_ready[0] = 1'b1;
    tick();
    chk("l3_idle", 32'({bus3.pop_req[0], bus3.out_valid[0]}), 32'd0);

    tick();
    chk("sb0_empty", 32'(q0.size()), 32'd0);
    chk("sb1_empty", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
